// File: rtl/funnel_ctrl_4_1.sv
// Funnel lane sequencer: holds a 512-bit word and walks the 4:1 funnel select over its lanes.
// Optional completed-word counter enabled by defining FUNNEL_CTRL_WORD_CNT_EN.
module funnel_ctrl_4_1 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [511:0]     t_dat,
   input  logic             t_valid,
   output logic             t_ready,
   input  logic [1:0]       t_cfg_lanes,
   output logic [511:0]     o_dat,
   output logic [7:0]       o_sel,
   output logic             o_valid,
   output logic             o_last,
   input  logic             o_ready,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t       state_q, state_d;
   logic [1:0]   k_q, k_d;
   logic [1:0]   lm_q, lm_d;
   logic [511:0] dat_q, dat_d;
   logic         accept;
   logic         fire;

   assign o_valid = (state_q == SEND);
   assign o_last  = o_valid && (k_q == lm_q);
   assign t_ready = !o_valid || (o_last && o_ready);
   assign accept  = t_valid && t_ready;
   assign fire    = o_valid && o_ready;
   assign o_dat   = dat_q;
   // Funnel select bits are the lane index bit-reversed.
   assign o_sel   = {6'b0, k_q[0], k_q[1]};

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      lm_d    = lm_q;
      dat_d   = dat_q;
      if (accept) begin
         state_d = SEND;
         k_d     = 2'd0;
         lm_d    = t_cfg_lanes;
         dat_d   = t_dat;
      end else if (fire) begin
         if (o_last) begin
            state_d = IDLE;
            k_d     = 2'd0;
         end else begin
            k_d = k_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
         lm_q    <= 2'd3;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         lm_q    <= lm_d;
         dat_q   <= dat_d;
      end
   end

`ifdef FUNNEL_CTRL_WORD_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (fire && o_last) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign word_cnt = cnt_q;
`else
   assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_funnel_ctrl_4_1.sv
// Directed bench for funnel_ctrl_4_1: cycle vector table plus reset and counter sequences.
module tb_funnel_ctrl_4_1;

   logic         clk;
   logic         reset_n;
   logic [511:0] t_dat;
   logic         t_valid;
   logic         t_ready;
   logic [1:0]   t_cfg_lanes;
   logic [511:0] o_dat;
   logic [7:0]   o_sel;
   logic         o_valid;
   logic         o_last;
   logic         o_ready;
   logic [1:0]   word_cnt;

   int errors = 0;
   int checks = 0;

   funnel_ctrl_4_1 #(.CNT_W(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .t_dat       (t_dat),
      .t_valid     (t_valid),
      .t_ready     (t_ready),
      .t_cfg_lanes (t_cfg_lanes),
      .o_dat       (o_dat),
      .o_sel       (o_sel),
      .o_valid     (o_valid),
      .o_last      (o_last),
      .o_ready     (o_ready),
      .word_cnt    (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       tv;
      logic [1:0] cfg;
      int         w;
      logic       rdy;
      logic       ev;
      logic [7:0] esel;
      logic       elast;
      logic       etr;
      int         ew;
      int         ek;
   } vec_t;

   vec_t v[28];

   function automatic logic [127:0] lane(int w, int k);
      return {32'(w), 32'(k), 32'hC0FFEE00, 32'(w * 16 + k)};
   endfunction

   function automatic logic [511:0] word(int w);
      return {lane(w, 3), lane(w, 2), lane(w, 1), lane(w, 0)};
   endfunction

   // Model of the downstream funnel output i_0_dat.
   function automatic logic [127:0] funnel_out(logic [511:0] d, logic [7:0] s);
      logic [1:0] k;
      k = {s[0], s[1]};
      return d[128 * k +: 128];
   endfunction

   function automatic vec_t mk(logic tv, logic [1:0] cfg, int w, logic rdy,
                               logic ev, logic [7:0] esel, logic elast,
                               logic etr, int ew, int ek);
      vec_t r;
      r.tv = tv; r.cfg = cfg; r.w = w; r.rdy = rdy;
      r.ev = ev; r.esel = esel; r.elast = elast; r.etr = etr;
      r.ew = ew; r.ek = ek;
      return r;
   endfunction

   task automatic chk(string nm, logic [511:0] got, logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, " o_valid"}, 512'(o_valid), 512'(0));
      chk({tag, " o_sel"}, 512'(o_sel), 512'(0));
      chk({tag, " o_last"}, 512'(o_last), 512'(0));
      chk({tag, " t_ready"}, 512'(t_ready), 512'(1));
      chk({tag, " o_dat"}, o_dat, 512'(0));
      chk({tag, " word_cnt"}, 512'(word_cnt), 512'(0));
   endtask

   initial begin
      logic [1:0] exp_cnt;

      reset_n     = 1'b0;
      t_valid     = 1'b0;
      t_dat       = '0;
      t_cfg_lanes = 2'd0;
      o_ready     = 1'b1;

      v[0]  = mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
      v[1]  = mk(1, 3, 1, 1, 0, 8'h00, 0, 1, 0, 0);
      v[2]  = mk(0, 0, 0, 1, 1, 8'h00, 0, 0, 1, 0);
      v[3]  = mk(0, 0, 0, 1, 1, 8'h02, 0, 0, 1, 1);
      v[4]  = mk(0, 0, 0, 1, 1, 8'h01, 0, 0, 1, 2);
      v[5]  = mk(0, 0, 0, 1, 1, 8'h03, 1, 1, 1, 3);
      v[6]  = mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
      v[7]  = mk(1, 1, 2, 1, 0, 8'h00, 0, 1, 0, 0);
      v[8]  = mk(1, 1, 3, 1, 1, 8'h00, 0, 0, 2, 0);
      v[9]  = mk(1, 1, 3, 1, 1, 8'h02, 1, 1, 2, 1);
      v[10] = mk(0, 0, 0, 1, 1, 8'h00, 0, 0, 3, 0);
      v[11] = mk(0, 0, 0, 1, 1, 8'h02, 1, 1, 3, 1);
      v[12] = mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
      v[13] = mk(1, 3, 4, 1, 0, 8'h00, 0, 1, 0, 0);
      v[14] = mk(0, 0, 0, 1, 1, 8'h00, 0, 0, 4, 0);
      v[15] = mk(0, 0, 0, 0, 1, 8'h02, 0, 0, 4, 1);
      v[16] = mk(0, 0, 0, 0, 1, 8'h02, 0, 0, 4, 1);
      v[17] = mk(0, 0, 0, 0, 1, 8'h02, 0, 0, 4, 1);
      v[18] = mk(0, 0, 0, 1, 1, 8'h02, 0, 0, 4, 1);
      v[19] = mk(0, 0, 0, 1, 1, 8'h01, 0, 0, 4, 2);
      v[20] = mk(0, 0, 0, 1, 1, 8'h03, 1, 1, 4, 3);
      v[21] = mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
      v[22] = mk(1, 0, 5, 1, 0, 8'h00, 0, 1, 0, 0);
      v[23] = mk(0, 0, 0, 0, 1, 8'h00, 1, 0, 5, 0);
      v[24] = mk(1, 0, 6, 0, 1, 8'h00, 1, 0, 5, 0);
      v[25] = mk(1, 0, 6, 1, 1, 8'h00, 1, 1, 5, 0);
      v[26] = mk(0, 0, 0, 1, 1, 8'h00, 1, 1, 6, 0);
      v[27] = mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 28; i++) begin
         t_valid     = v[i].tv;
         t_cfg_lanes = v[i].cfg;
         t_dat       = word(v[i].w);
         o_ready     = v[i].rdy;
         @(negedge clk);
         chk($sformatf("row%0d o_valid", i), 512'(o_valid), 512'(v[i].ev));
         chk($sformatf("row%0d o_sel", i), 512'(o_sel), 512'(v[i].esel));
         chk($sformatf("row%0d o_last", i), 512'(o_last), 512'(v[i].elast));
         chk($sformatf("row%0d t_ready", i), 512'(t_ready), 512'(v[i].etr));
         if (v[i].ev)
            chk($sformatf("row%0d lane", i), 512'(funnel_out(o_dat, o_sel)),
                512'(lane(v[i].ew, v[i].ek)));
         step();
      end

      t_valid     = 1'b1;
      t_cfg_lanes = 2'd3;
      t_dat       = word(7);
      o_ready     = 1'b1;
      step();
      t_valid = 1'b0;
      step();
      step();
      chk("midword o_sel", 512'(o_sel), 512'(8'h01));
      chk("midword lane", 512'(funnel_out(o_dat, o_sel)), 512'(lane(7, 2)));
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_state("async rst");
      step();
      chk("rst held o_valid", 512'(o_valid), 512'(0));
      reset_n = 1'b1;
      step();
      chk("post rst o_valid", 512'(o_valid), 512'(0));
      t_valid     = 1'b1;
      t_cfg_lanes = 2'd3;
      t_dat       = word(8);
      step();
      t_valid = 1'b0;
      chk("restart o_valid", 512'(o_valid), 512'(1));
      chk("restart o_sel", 512'(o_sel), 512'(8'h00));
      chk("restart lane", 512'(funnel_out(o_dat, o_sel)), 512'(lane(8, 0)));

      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      step();
      t_valid     = 1'b1;
      t_cfg_lanes = 2'd0;
      t_dat       = word(9);
      step();
      chk("cnt start", 512'(word_cnt), 512'(0));
      for (int n = 1; n <= 5; n++) begin
         step();
`ifdef FUNNEL_CTRL_WORD_CNT_EN
         exp_cnt = 2'(n);
`else
         exp_cnt = 2'd0;
`endif
         chk($sformatf("word_cnt n=%0d", n), 512'(word_cnt), 512'(exp_cnt));
      end
      t_valid = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/funnel_ctrl_4_1.md
FUNNEL_CTRL_4_1 -- requirements
Module: funnel_ctrl_4_1

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-word counter.
REQ-002 SHALL have ports, one per line below; clock and reset first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 t_dat  input  512  upstream word; lane k = t_dat[128k+127:128k].
REQ-006 t_valid  input  1  upstream word valid.
REQ-007 t_ready  output  1  block accepts t_dat this cycle.
REQ-008 t_cfg_lanes  input  2  number of lanes to emit minus 1; sampled with each accepted word.
REQ-009 o_dat  output  512  held word, drives the funnel's t_0_dat.
REQ-010 o_sel  output  8  funnel select; o_sel[7:2] always 0.
REQ-011 o_valid  output  1  funnel i_0_dat carries a valid lane this cycle.
REQ-012 o_last  output  1  current lane is the final lane of the word.
REQ-013 o_ready  input  1  downstream consumes the lane when o_valid && o_ready.
REQ-014 word_cnt  output  CNT_W  completed-word counter.

Function
REQ-015 SHALL use FSM states IDLE (no word held) and SEND (word held, emitting lanes).
REQ-016 t_ready SHALL be 1 in IDLE, and 1 in SEND only when o_last && o_ready; otherwise 0.
REQ-017 On t_valid && t_ready, SHALL register t_dat into o_dat, t_cfg_lanes into lane_max, and lane index to 0, and enter or stay in SEND.
REQ-018 o_valid SHALL equal (state == SEND), with no combinational path from t_valid.
REQ-019 Lane index k (2 bits) SHALL map to o_sel[0] = k[1], o_sel[1] = k[0], so the funnel's i_0_dat output presents lane k.
REQ-020 o_last SHALL equal (state == SEND) && (k == lane_max).
REQ-021 On o_valid && o_ready && !o_last, k SHALL increment by 1 the next cycle.
REQ-022 On o_valid && o_ready && o_last without a new accept, SHALL return to IDLE with k = 0.
REQ-023 On o_valid && o_ready && o_last with t_valid, SHALL load the next word in the same cycle; lanes stream back-to-back with no bubble.
REQ-024 While o_valid && !o_ready, o_dat, o_sel, k and o_last SHALL hold stable.
REQ-025 Latency from a t_dat accept to the first o_valid SHALL be 1 cycle.
REQ-026 Throughput SHALL be lane_max+1 cycles per word at o_ready = 1.
REQ-027 o_dat SHALL change only on an accept.
REQ-028 lane_max = 0 SHALL emit a single lane (lane 0) with o_last = 1.

Reset
REQ-029 While reset_n = 0, asynchronously: state = IDLE, k = 0, lane_max = 3, o_dat = 0, o_sel = 0, o_valid = 0, o_last = 0, word_cnt = 0, t_ready = 1.
REQ-030 Reset asserted mid-word SHALL discard the held word with no further o_valid until a new accept.

Configuration
REQ-031 Macro FUNNEL_CTRL_WORD_CNT_EN SHALL control the completed-word counter.
REQ-032 With FUNNEL_CTRL_WORD_CNT_EN defined, word_cnt SHALL increment by 1 on each o_valid && o_ready && o_last and wrap from 2^CNT_W-1 to 0.
REQ-033 Without FUNNEL_CTRL_WORD_CNT_EN, word_cnt SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-034 Accept t_dat lanes {0:A,1:B,2:C,3:D}, cfg = 3, o_ready = 1 -> o_sel = 0x00, 0x02, 0x01, 0x03 on four consecutive cycles; o_last only on the fourth; funnel i_0_dat yields A, B, C, D.
REQ-035 Two words with t_valid held high, cfg = 1 -> 4 consecutive o_valid cycles, no bubble, t_ready = 1 on cycles 2 and 4 only.
REQ-036 o_ready = 0 for 3 cycles at lane 1 -> o_sel holds at 0x02, t_ready = 0; resumes at lane 2 when o_ready returns to 1.
REQ-037 reset_n = 0 pulsed at lane 2 -> o_valid = 0 immediately; next accept restarts at lane 0.
REQ-038 With the macro defined and CNT_W = 2, complete 5 words at cfg = 0 -> word_cnt sequence 1, 2, 3, 0, 1; without the macro, word_cnt stays 0.
